apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
APB initiator that turns a simple valid/ready command stream from the processor-side logic into APB transfers toward the slave interfaces (GPIO on psel[0], UART on psel[1]). It runs the two-phase SETUP/ACCESS protocol and waits on pready. It applies a wait-state timeout and returns a single response per command (read data plus status) on a valid/ready response port. Exactly one transfer is outstanding at a time.

Parameters:
ADDR_W, 32, width of pAdd and cmd_addr
DATA_W, 32, width of pwData, prdata, cmd_wdata, rsp_rdata
NSEL, 2, number of one-hot slave selects (bit0 GPIO, bit1 UART)
TIMEOUT, 255, max extra ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  bridge accepts command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
cmd_sel  in  NSEL  one-hot target slave
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_code  out  2  00 OK, 01 timeout, 10 bad select
pAdd  out  ADDR_W  APB address
pwData  out  DATA_W  APB write data
psel  out  NSEL  APB select
pen  out  1  APB enable
pwr  out  1  APB write
prdata  in  DATA_W  APB read data
pready  in  1  APB ready

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. cmd_ready=0 during reset, 1 on the first cycle after. rsp_valid=0, rsp_rdata=0, rsp_code=00, pAdd=0, pwData=0, psel=0, pen=0, pwr=0, wait counter=0. Reset mid-transfer aborts immediately. No response is produced for the aborted command.
- All outputs are registered. cmd_ready=1 only in IDLE.
- FSM: IDLE, SETUP, ACCESS, RESP.
- IDLE: on cmd_valid&cmd_ready, capture write/addr/wdata/sel.
  - If cmd_sel is zero or not one-hot: go to RESP with rsp_code=10 and rsp_rdata=0. No APB activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle): psel=captured sel, pen=0, pwr=cmd_write, pAdd=addr, pwData=wdata (writes only; reads keep previous pwData). Wait counter cleared. Next state is ACCESS.
- ACCESS: pen=1. psel, pAdd, pwr and pwData are held stable.
  - pready=1: transfer completes. For a read, rsp_rdata=prdata sampled that edge; for a write, rsp_rdata=0. rsp_code=00. Go to RESP.
  - pready=0 and TIMEOUT!=0 and counter==TIMEOUT: abort with rsp_code=01, rsp_rdata=0. Go to RESP.
  - Otherwise: counter+1 (saturating width clog2(TIMEOUT+1)). Stay in ACCESS.
  - pready=1 takes priority on the timeout cycle.
  - A hung slave gives exactly TIMEOUT+1 ACCESS cycles.
- Leaving ACCESS: psel=0, pen=0, pwr=0. pAdd and pwData hold their last values.
- RESP: rsp_valid=1, with rdata and code stable until rsp_ready=1 at a clock edge. Then rsp_valid=0 and go to IDLE. rsp_ready outside RESP is ignored.
- Latency: accept edge at cycle 0, SETUP in cycle 1, ACCESS in cycle 2. With zero wait states, rsp_valid is high in cycle 3. Minimum 4 cycles per command (RESP + IDLE); no back-to-back overlap.
- psel never has more than one bit set. pen=1 only while psel is nonzero.

Test Plan:
1. Write, zero wait: cmd addr=0x10, wdata=0xA5A5_0001, sel=10, pready tied 1 -> SETUP psel=10/pen=0/pwr=1, next cycle pen=1, then rsp_valid with code 00 and rdata 0. One ACCESS cycle only.
2. Read with 3 wait states: sel=01, pready low for 3 ACCESS cycles then high with prdata=0xDEAD_BEEF -> 4 ACCESS cycles, address held stable, rsp_rdata=0xDEAD_BEEF, code 00.
3. Timeout with TIMEOUT=4 and pready never high -> exactly 5 ACCESS cycles, then psel=0/pen=0 and rsp_code=01, rdata 0. Repeat with pready rising on the 5th ACCESS cycle -> code 00.
4. Bad select: cmd_sel=00, then 11 -> no psel/pen toggles, rsp_code=10 in the cycle after accept.
5. Response backpressure: rsp_ready low for 6 cycles -> rsp_valid, rdata and code stable. cmd_ready=0 throughout. The next command is accepted only after the rsp_ready handshake.
6. Reset during ACCESS: assert rst_n=0 on the 2nd wait cycle -> next edge psel=0, pen=0, rsp_valid=0. After release, cmd_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one valid/ready command at a time into an APB SETUP/ACCESS transfer
// and returns one response (read data plus status) per command, with a wait-state timeout.
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSEL    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [NSEL-1:0]   cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_code,
    output logic [ADDR_W-1:0] pAdd,
    output logic [DATA_W-1:0] pwData,
    output logic [NSEL-1:0]   psel,
    output logic              pen,
    output logic              pwr,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] CodeOk      = 2'b00;
    localparam logic [1:0] CodeTimeout = 2'b01;
    localparam logic [1:0] CodeBadSel  = 2'b10;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             sel_onehot;
    logic             timeout_hit;

    always_comb begin
        sel_onehot  = (cmd_sel != '0) && ((cmd_sel & (cmd_sel - NSEL'(1))) == '0);
        timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_code  <= CodeOk;
            pAdd      <= '0;
            pwData    <= '0;
            psel      <= '0;
            pen       <= 1'b0;
            pwr       <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (!sel_onehot) begin
                            // Bad select never touches the bus.
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_code  <= CodeBadSel;
                        end else begin
                            state    <= StSetup;
                            psel     <= cmd_sel;
                            pwr      <= cmd_write;
                            pAdd     <= cmd_addr;
                            wait_cnt <= '0;
                            if (cmd_write) begin
                                pwData <= cmd_wdata;
                            end
                        end
                    end
                end
                StSetup: begin
                    state <= StAccess;
                    pen   <= 1'b1;
                end
                StAccess: begin
                    if (pready || timeout_hit) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_code  <= pready ? CodeOk : CodeTimeout;
                        rsp_rdata <= (pready && !pwr) ? prdata : '0;
                        psel      <= '0;
                        pen       <= 1'b0;
                        pwr       <= 1'b0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized bench for apb_master_bridge; expected responses and bus timing
// come from a transaction-level model of the command rules.
module tb_apb_master_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_code;
    logic [31:0] pAdd, pwData, prdata;
    logic [1:0]  psel;
    logic        pen, pwr, pready;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_pwdata;

    apb_master_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .NSEL   (2),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_code (rsp_code),
        .pAdd     (pAdd),
        .pwData   (pwData),
        .psel     (psel),
        .pen      (pen),
        .pwr      (pwr),
        .prdata   (prdata),
        .pready   (pready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One command end to end. nwait = number of low-pready ACCESS cycles the slave inserts.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] sel, input int nwait, input logic [31:0] rd,
                           input int rdelay);
        logic        good;
        int          n_acc;
        logic [1:0]  code;
        logic [31:0] exp_rd;
        good  = (sel == 2'b01) || (sel == 2'b10);
        n_acc = (nwait <= int'(TO)) ? nwait + 1 : int'(TO) + 1;
        code  = !good ? 2'b10 : (nwait <= int'(TO)) ? 2'b00 : 2'b01;
        exp_rd = (code == 2'b00 && !wr) ? rd : 32'h0;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'h1);
        step();
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        cmd_addr  = $urandom;

        if (good) begin
            if (wr) last_pwdata = wdata;
            chk("setup_psel", {30'b0, psel}, {30'b0, sel});
            chk("setup_pen", {31'b0, pen}, 32'h0);
            chk("setup_pwr", {31'b0, pwr}, {31'b0, wr});
            chk("setup_paddr", pAdd, addr);
            chk("setup_pwdata", pwData, last_pwdata);
            step();
            for (int i = 0; i < n_acc; i++) begin
                pready = (i == nwait);
                prdata = (i == nwait) ? rd : $urandom;
                chk("acc_pen", {31'b0, pen}, 32'h1);
                chk("acc_psel", {30'b0, psel}, {30'b0, sel});
                chk("acc_paddr", pAdd, addr);
                chk("acc_pwdata", pwData, last_pwdata);
                chk("acc_rsp_valid", {31'b0, rsp_valid}, 32'h0);
                step();
            end
            pready = 1'b0;
            chk("post_paddr_held", pAdd, addr);
        end
        chk("resp_psel", {30'b0, psel}, 32'h0);
        chk("resp_pen", {31'b0, pen}, 32'h0);
        chk("resp_pwr", {31'b0, pwr}, 32'h0);

        // Another command offered during backpressure must not be taken.
        for (int d = 0; d < rdelay; d++) begin
            cmd_valid = 1'b1;
            chk("resp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("resp_rdata", rsp_rdata, exp_rd);
            chk("resp_code", {30'b0, rsp_code}, {30'b0, code});
            chk("resp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
            step();
            chk("resp_no_psel", {30'b0, psel}, 32'h0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("resp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("resp_rdata", rsp_rdata, exp_rd);
        chk("resp_code", {30'b0, rsp_code}, {30'b0, code});
        step();
        rsp_ready = 1'b0;
        chk("done_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("done_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    endtask

    initial begin
        logic [1:0] sel_tbl [4];
        sel_tbl[0] = 2'b01; sel_tbl[1] = 2'b10; sel_tbl[2] = 2'b00; sel_tbl[3] = 2'b11;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_sel = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; last_pwdata = '0;
        step();
        step();
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_code", {30'b0, rsp_code}, 32'h0);
        chk("rst_paddr", pAdd, 32'h0);
        chk("rst_pwdata", pwData, 32'h0);
        chk("rst_psel", {30'b0, psel}, 32'h0);
        chk("rst_pen_pwr", {30'b0, pen, pwr}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);

        run_cmd(1'b1, 32'h10, 32'hA5A5_0001, 2'b10, 0, 32'h1234_5678, 0);
        run_cmd(1'b0, 32'h24, 32'h0, 2'b01, 3, 32'hDEAD_BEEF, 0);
        run_cmd(1'b0, 32'h30, 32'h0, 2'b01, 100, 32'h5555_AAAA, 0);
        run_cmd(1'b1, 32'h34, 32'h7777_0000, 2'b10, 4, 32'h0, 1);
        run_cmd(1'b0, 32'h38, 32'h0, 2'b01, 4, 32'hCAFE_0004, 0);
        run_cmd(1'b1, 32'h40, 32'h1, 2'b00, 0, 32'h0, 0);
        run_cmd(1'b0, 32'h44, 32'h2, 2'b11, 0, 32'h0, 0);
        run_cmd(1'b0, 32'h48, 32'h0, 2'b10, 1, 32'h0BAD_F00D, 6);

        // Reset on the second wait cycle of a read.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; cmd_sel = 2'b01;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("pre_rst_pen", {31'b0, pen}, 32'h1);
        rst_n = 1'b0;
        step();
        chk("midrst_psel", {30'b0, psel}, 32'h0);
        chk("midrst_pen", {31'b0, pen}, 32'h0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        rst_n = 1'b1;
        last_pwdata = '0;
        step();
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        step();
        chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        run_cmd(1'b1, 32'h54, 32'h0102_0304, 2'b10, 0, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom,
                    sel_tbl[$urandom_range(0, 3)], int'($urandom_range(0, 6)), $urandom,
                    int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
